// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared state encoding for the binary-to-BCD stream converter
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_add3.sv
// rtl/bcd_add3.sv - double-dabble digit correction: add 3 when the digit exceeds 4
module bcd_add3 (
  input  logic [3:0] d,
  output logic [3:0] q
);

  assign q = (d > 4'd4) ? d + 4'd3 : d;

endmodule

// File: rtl/bin2bcd_stream.sv
// rtl/bin2bcd_stream.sv - sequential binary to packed-BCD converter with valid/ready handshakes
module bin2bcd_stream
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 32,
  parameter int DIGITS = 10,
  parameter int SIGNED = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BIN_W-1:0]    din,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] bcd,
  output logic                neg,
  output logic                ovf,
  output logic [DIGITS-1:0]   lz_mask
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int BCD_W = 4 * DIGITS;

  state_t             state;
  logic [BIN_W-1:0]   mag;
  logic [CNT_W-1:0]   cnt;
  logic [BCD_W-1:0]   adj;
  logic [BCD_W-1:0]   bcd_next;
  logic               shout;
  logic [DIGITS-1:0]  lz_next;
  logic               zero_above;
  logic               din_neg;
  logic [BIN_W-1:0]   din_mag;

  // Two's complement negate also covers -2^(BIN_W-1): it maps onto itself as an unsigned value.
  assign din_neg = (SIGNED != 0) && din[BIN_W-1];
  assign din_mag = din_neg ? (~din + BIN_W'(1)) : din;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_add3 u_add3 (
      .d (bcd[4*g +: 4]),
      .q (adj[4*g +: 4])
    );
  end

  // Whatever leaves the top digit is lost magnitude, hence overflow.
  assign {shout, bcd_next} = {adj, mag[BIN_W-1]};

  always_comb begin
    lz_next    = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above & (bcd_next[4*i +: 4] == 4'd0);
      lz_next[i] = zero_above;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      mag       <= '0;
      cnt       <= '0;
      bcd       <= '0;
      neg       <= 1'b0;
      ovf       <= 1'b0;
      lz_mask   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mag      <= din_mag;
            neg      <= din_neg;
            bcd      <= '0;
            ovf      <= 1'b0;
            lz_mask  <= '0;
            cnt      <= CNT_W'(BIN_W);
            in_ready <= 1'b0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          bcd <= bcd_next;
          mag <= mag << 1;
          ovf <= ovf | shout;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            lz_mask   <= lz_next;
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_stream.sv
// tb/tb_bin2bcd_stream.sv - directed self-checking bench for bin2bcd_stream
module tb_bin2bcd_stream;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic out_ready = 1'b0;

  logic        d_in_valid = 1'b0, d_in_ready, d_out_valid, d_neg, d_ovf;
  logic [31:0] d_din = '0;
  logic [39:0] d_bcd;
  logic [9:0]  d_lz;

  logic        s_in_valid = 1'b0, s_in_ready, s_out_valid, s_neg, s_ovf;
  logic [31:0] s_din = '0;
  logic [39:0] s_bcd;
  logic [9:0]  s_lz;

  logic        m_in_valid = 1'b0, m_in_ready, m_out_valid, m_neg, m_ovf;
  logic [7:0]  m_din = '0;
  logic [7:0]  m_bcd;
  logic [1:0]  m_lz;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bin2bcd_stream u_def (
    .clk(clk), .rst_n(rst_n), .in_valid(d_in_valid), .in_ready(d_in_ready), .din(d_din),
    .out_valid(d_out_valid), .out_ready(out_ready), .bcd(d_bcd), .neg(d_neg), .ovf(d_ovf),
    .lz_mask(d_lz)
  );

  bin2bcd_stream #(.BIN_W(32), .DIGITS(10), .SIGNED(1)) u_sgn (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready), .din(s_din),
    .out_valid(s_out_valid), .out_ready(out_ready), .bcd(s_bcd), .neg(s_neg), .ovf(s_ovf),
    .lz_mask(s_lz)
  );

  bin2bcd_stream #(.BIN_W(8), .DIGITS(2), .SIGNED(0)) u_sml (
    .clk(clk), .rst_n(rst_n), .in_valid(m_in_valid), .in_ready(m_in_ready), .din(m_din),
    .out_valid(m_out_valid), .out_ready(out_ready), .bcd(m_bcd), .neg(m_neg), .ovf(m_ovf),
    .lz_mask(m_lz)
  );

  task automatic conv_def(input logic [31:0] v, output int lat);
    @(negedge clk); d_din = v; d_in_valid = 1'b1;
    @(posedge clk); #1 d_in_valid = 1'b0; d_din = ~v;
    lat = 1;
    while (!d_out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic conv_sgn(input logic [31:0] v, output int lat);
    @(negedge clk); s_din = v; s_in_valid = 1'b1;
    @(posedge clk); #1 s_in_valid = 1'b0; s_din = ~v;
    lat = 1;
    while (!s_out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic conv_sml(input logic [7:0] v, output int lat);
    @(negedge clk); m_din = v; m_in_valid = 1'b1;
    @(posedge clk); #1 m_in_valid = 1'b0; m_din = ~v;
    lat = 1;
    while (!m_out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic take;
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (d_in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b exp 1", d_in_ready); end
    n_cmp++; if (d_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b exp 0", d_out_valid); end
    n_cmp++; if ({d_bcd, d_neg, d_ovf, d_lz} !== 52'h0) begin n_err++; $display("FAIL reset_outputs got %h exp 0", {d_bcd, d_neg, d_ovf, d_lz}); end
    n_cmp++; if ({s_out_valid, m_out_valid, s_in_ready, m_in_ready} !== 4'b0011) begin n_err++; $display("FAIL reset_other got %b exp 0011", {s_out_valid, m_out_valid, s_in_ready, m_in_ready}); end
  endtask

  task automatic test_zero;
    int lat;
    conv_def(32'h0, lat);
    n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL zero_latency got %0d exp 33", lat); end
    n_cmp++; if (d_bcd !== 40'h0) begin n_err++; $display("FAIL zero_bcd got %h exp 0", d_bcd); end
    n_cmp++; if (d_ovf !== 1'b0) begin n_err++; $display("FAIL zero_ovf got %b exp 0", d_ovf); end
    n_cmp++; if (d_lz !== 10'h3FE) begin n_err++; $display("FAIL zero_lz got %h exp 3fe", d_lz); end
    n_cmp++; if (d_in_ready !== 1'b0) begin n_err++; $display("FAIL zero_in_ready_hold got %b exp 0", d_in_ready); end
    take();
    n_cmp++; if ({d_in_ready, d_out_valid} !== 2'b10) begin n_err++; $display("FAIL zero_after_take got %b exp 10", {d_in_ready, d_out_valid}); end
  endtask

  task automatic test_max;
    int lat;
    conv_def(32'hFFFFFFFF, lat);
    n_cmp++; if (d_bcd !== 40'h4294967295) begin n_err++; $display("FAIL max_bcd got %h exp 4294967295", d_bcd); end
    n_cmp++; if ({d_ovf, d_neg, d_lz} !== 12'h0) begin n_err++; $display("FAIL max_flags got %h exp 0", {d_ovf, d_neg, d_lz}); end
    take();
    conv_def(32'd12345678, lat);
    n_cmp++; if (d_bcd !== 40'h0012345678) begin n_err++; $display("FAIL mid_bcd got %h exp 12345678", d_bcd); end
    n_cmp++; if (d_lz !== 10'h300) begin n_err++; $display("FAIL mid_lz got %h exp 300", d_lz); end
    take();
  endtask

  task automatic test_signed;
    int lat;
    conv_sgn(32'hFFFFFFFF, lat);
    n_cmp++; if ({s_neg, s_bcd} !== {1'b1, 40'h1}) begin n_err++; $display("FAIL sgn_m1 got %b/%h exp 1/1", s_neg, s_bcd); end
    n_cmp++; if (s_lz !== 10'h3FE) begin n_err++; $display("FAIL sgn_m1_lz got %h exp 3fe", s_lz); end
    take();
    conv_sgn(32'h80000000, lat);
    n_cmp++; if ({s_neg, s_bcd} !== {1'b1, 40'h2147483648}) begin n_err++; $display("FAIL sgn_min got %b/%h exp 1/2147483648", s_neg, s_bcd); end
    n_cmp++; if ({s_ovf, s_lz} !== 11'h0) begin n_err++; $display("FAIL sgn_min_flags got %h exp 0", {s_ovf, s_lz}); end
    take();
    conv_sgn(32'd305, lat);
    n_cmp++; if ({s_neg, s_bcd} !== {1'b0, 40'h305}) begin n_err++; $display("FAIL sgn_pos got %b/%h exp 0/305", s_neg, s_bcd); end
    take();
  endtask

  task automatic test_small;
    int lat;
    conv_sml(8'd255, lat);
    n_cmp++; if (lat !== 9) begin n_err++; $display("FAIL sml_latency got %0d exp 9", lat); end
    n_cmp++; if ({m_ovf, m_bcd} !== {1'b1, 8'h55}) begin n_err++; $display("FAIL sml_255 got %b/%h exp 1/55", m_ovf, m_bcd); end
    take();
    conv_sml(8'd99, lat);
    n_cmp++; if ({m_ovf, m_bcd, m_lz} !== {1'b0, 8'h99, 2'b00}) begin n_err++; $display("FAIL sml_99 got %b/%h/%b exp 0/99/00", m_ovf, m_bcd, m_lz); end
    take();
    conv_sml(8'd100, lat);
    n_cmp++; if ({m_ovf, m_bcd} !== {1'b1, 8'h00}) begin n_err++; $display("FAIL sml_100 got %b/%h exp 1/00", m_ovf, m_bcd); end
    take();
    conv_sml(8'd5, lat);
    n_cmp++; if ({m_ovf, m_bcd, m_lz, m_neg} !== {1'b0, 8'h05, 2'b10, 1'b0}) begin n_err++; $display("FAIL sml_5 got %b/%h/%b/%b exp 0/05/10/0", m_ovf, m_bcd, m_lz, m_neg); end
    take();
  endtask

  task automatic test_hold;
    int lat;
    int bad;
    conv_def(32'd90817, lat);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); d_in_valid = i[0]; d_din = 32'd5;
      @(posedge clk); #1;
      if (d_bcd !== 40'h90817 || d_out_valid !== 1'b1 || d_in_ready !== 1'b0 || d_lz !== 10'h3E0 || d_ovf !== 1'b0) bad++;
    end
    d_in_valid = 1'b0;
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL hold_stable got %0d bad cycles exp 0", bad); end
    take();
    @(posedge clk); #1;
    n_cmp++; if ({d_in_ready, d_out_valid} !== 2'b10) begin n_err++; $display("FAIL hold_ignored_input got %b exp 10", {d_in_ready, d_out_valid}); end
  endtask

  task automatic test_back_to_back;
    int lat;
    conv_def(32'd7, lat);
    // Keep in_valid high through the handshake: it must be taken only the cycle after.
    @(negedge clk); out_ready = 1'b1; d_in_valid = 1'b1; d_din = 32'd1000;
    @(posedge clk); #1 out_ready = 1'b0;
    n_cmp++; if ({d_in_ready, d_out_valid} !== 2'b10) begin n_err++; $display("FAIL b2b_handshake got %b exp 10", {d_in_ready, d_out_valid}); end
    @(posedge clk); #1 d_in_valid = 1'b0; d_din = '0;
    n_cmp++; if (d_in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_accept got %b exp 0", d_in_ready); end
    lat = 1;
    while (!d_out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    n_cmp++; if ({lat, d_bcd} !== {32'd33, 40'h1000}) begin n_err++; $display("FAIL b2b_second got %0d/%h exp 33/1000", lat, d_bcd); end
    take();
  endtask

  task automatic test_reset_mid;
    int lat;
    int seen;
    @(negedge clk); d_din = 32'd987654; d_in_valid = 1'b1;
    @(posedge clk); #1 d_in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if ({d_out_valid, d_bcd, d_ovf, d_neg, d_lz} !== 53'h0) begin n_err++; $display("FAIL rstmid_async got %h exp 0", {d_out_valid, d_bcd, d_ovf, d_neg, d_lz}); end
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin @(posedge clk); #1; if (d_out_valid) seen++; end
    n_cmp++; if ({seen, d_in_ready} !== {32'd0, 1'b1}) begin n_err++; $display("FAIL rstmid_no_output got %0d/%b exp 0/1", seen, d_in_ready); end
    conv_def(32'd1234, lat);
    n_cmp++; if ({d_bcd, d_lz} !== {40'h1234, 10'h3F0}) begin n_err++; $display("FAIL rstmid_next got %h/%h exp 1234/3f0", d_bcd, d_lz); end
    take();
  endtask

  initial begin
    test_reset();
    test_zero();
    test_max();
    test_signed();
    test_small();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
